// File: rtl/frame_mode_pkg.sv
// Shared types and constants for the frame capture / mode-switch controller.
package frame_mode_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_SOF = 3'd1,
        ST_RUN      = 3'd2,
        ST_FLUSH    = 3'd3,
        ST_SNAP     = 3'd4
    } state_t;

    localparam logic [1:0] MODE_RGB_A  = 2'b00;
    localparam logic [1:0] MODE_RGB_B  = 2'b01;
    localparam logic [1:0] MODE_EDGE_V = 2'b10;
    localparam logic [1:0] MODE_EDGE_H = 2'b11;

    localparam int FLUSH_FRAMES_DEF = 1;

    typedef struct packed {
        logic sel_edge;
        logic horiz;
    } mode_t;

    function automatic mode_t decode_mode(input logic [1:0] sw);
        mode_t m;
        m = '0;
        case (sw)
            MODE_RGB_A, MODE_RGB_B: m = '{sel_edge: 1'b0, horiz: 1'b0};
            MODE_EDGE_V:            m = '{sel_edge: 1'b1, horiz: 1'b0};
            MODE_EDGE_H:            m = '{sel_edge: 1'b1, horiz: 1'b1};
            default:                m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sync_pulse.sv
// Two-flop synchroniser for an active-low key, with a one-cycle pulse on the
// synchronised falling edge.
module sync_pulse (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pulse
);

    // [0],[1] synchronise; [2] is the previous synchronised level
    logic [2:0] sh;

    always_ff @(posedge clk) begin
        if (rst) sh <= 3'b111;
        else     sh <= {sh[1:0], key_n};
    end

    assign pulse = sh[2] & ~sh[1];

endmodule

// File: rtl/frame_mode_ctrl.sv
// Frame-aligned capture control: arms, stops and snapshots whole frames and
// switches the RGB/edge source only on frame boundaries.
//
// state       | meaning
// ST_IDLE     | no capture, waiting for start or snap key
// ST_WAIT_SOF | armed, waiting for the next start of frame
// ST_RUN      | continuous capture, every frame written
// ST_FLUSH    | writes suppressed for FLUSH_FRAMES frames after a mode change
// ST_SNAP     | writing exactly one frame
module frame_mode_ctrl
    import frame_mode_pkg::*;
#(
    parameter int FLUSH_FRAMES = FLUSH_FRAMES_DEF,
    parameter int CNT_W        = 16
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iFVAL,
    input  logic             iDVAL_RGB,
    input  logic             iDVAL_EDGE,
    input  logic [1:0]       iMODE_SW,
    input  logic             iSTART_N,
    input  logic             iSTOP_N,
    input  logic             iSNAP_N,
    output logic             oSEL_EDGE,
    output logic             oHORIZ,
    output logic             oDVAL,
    output logic [CNT_W-1:0] oFRAME_CNT,
    output logic             oSNAP_DONE,
    output logic             oBUSY
);

    localparam logic [3:0]       FLUSH_LIM = 4'(FLUSH_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic start_p, stop_p, snap_p;
    logic [1:0] mode_s1, mode_s2;
    mode_t mode_pend, mode_act;
    logic fval_d, sof, eof, mode_diff;

    state_t state, state_nxt;
    logic wen, wen_nxt;
    logic snap_flag, snap_flag_nxt;
    logic stop_pend, stop_pend_nxt;
    logic [3:0] flush_cnt, flush_cnt_nxt;
    logic [CNT_W-1:0] frame_cnt, frame_cnt_nxt;
    logic snap_done, snap_done_nxt;

    sync_pulse u_sync_start (.clk(iCLK), .rst(iRST), .key_n(iSTART_N), .pulse(start_p));
    sync_pulse u_sync_stop  (.clk(iCLK), .rst(iRST), .key_n(iSTOP_N),  .pulse(stop_p));
    sync_pulse u_sync_snap  (.clk(iCLK), .rst(iRST), .key_n(iSNAP_N),  .pulse(snap_p));

    assign sof       = iFVAL & ~fval_d;
    assign eof       = ~iFVAL & fval_d;
    assign mode_diff = (mode_pend != mode_act);

    // Active mode only moves at SOF so a frame never mixes sources.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            fval_d    <= 1'b0;
            mode_s1   <= 2'b00;
            mode_s2   <= 2'b00;
            mode_pend <= '0;
            mode_act  <= '0;
        end else begin
            fval_d    <= iFVAL;
            mode_s1   <= iMODE_SW;
            mode_s2   <= mode_s1;
            mode_pend <= decode_mode(mode_s2);
            if (sof) mode_act <= mode_pend;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= ST_IDLE;
            wen       <= 1'b0;
            snap_flag <= 1'b0;
            stop_pend <= 1'b0;
            flush_cnt <= '0;
            frame_cnt <= '0;
            snap_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            wen       <= wen_nxt;
            snap_flag <= snap_flag_nxt;
            stop_pend <= stop_pend_nxt;
            flush_cnt <= flush_cnt_nxt;
            frame_cnt <= frame_cnt_nxt;
            snap_done <= snap_done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        snap_flag_nxt = snap_flag;
        stop_pend_nxt = stop_pend;
        flush_cnt_nxt = flush_cnt;
        frame_cnt_nxt = frame_cnt;
        snap_done_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                stop_pend_nxt = 1'b0;
                if (!stop_p && start_p) begin
                    state_nxt     = ST_WAIT_SOF;
                    snap_flag_nxt = 1'b0;
                end else if (!stop_p && snap_p) begin
                    state_nxt     = ST_WAIT_SOF;
                    snap_flag_nxt = 1'b1;
                end
            end
            ST_WAIT_SOF: begin
                if (stop_p) begin
                    state_nxt     = ST_IDLE;
                    snap_flag_nxt = 1'b0;
                end else if (sof) begin
                    if (mode_diff) begin
                        state_nxt     = ST_FLUSH;
                        flush_cnt_nxt = '0;
                    end else begin
                        state_nxt = snap_flag ? ST_SNAP : ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (stop_p) stop_pend_nxt = 1'b1;
                if (sof && mode_diff) begin
                    state_nxt     = ST_FLUSH;
                    flush_cnt_nxt = '0;
                end else if (eof) begin
                    frame_cnt_nxt = frame_cnt + CNT_ONE;
                    if (stop_pend || stop_p) begin
                        state_nxt     = ST_IDLE;
                        stop_pend_nxt = 1'b0;
                    end
                end
            end
            ST_FLUSH: begin
                // a stop left pending from RUN also ends the flush
                if (stop_p || stop_pend) begin
                    state_nxt     = ST_IDLE;
                    snap_flag_nxt = 1'b0;
                    stop_pend_nxt = 1'b0;
                end else begin
                    if (eof && (flush_cnt < FLUSH_LIM)) flush_cnt_nxt = flush_cnt + 4'd1;
                    if (sof && (flush_cnt >= FLUSH_LIM))
                        state_nxt = snap_flag ? ST_SNAP : ST_RUN;
                end
            end
            ST_SNAP: begin
                if (eof) begin
                    frame_cnt_nxt = frame_cnt + CNT_ONE;
                    snap_done_nxt = 1'b1;
                    snap_flag_nxt = 1'b0;
                    state_nxt     = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        wen_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_SNAP);
    end

    assign oSEL_EDGE  = mode_act.sel_edge;
    assign oHORIZ     = mode_act.horiz;
    assign oDVAL      = wen & (mode_act.sel_edge ? iDVAL_EDGE : iDVAL_RGB);
    assign oFRAME_CNT = frame_cnt;
    assign oSNAP_DONE = snap_done;
    assign oBUSY      = (state != ST_IDLE);

endmodule

// File: tb/tb_frame_mode_ctrl.sv
// Self-checking bench for frame_mode_ctrl: directed frame table, corner
// sequences, and random frame-level stimulus against a frame-level model.
module tb_frame_mode_ctrl;

    localparam int CW = 4;
    localparam int FF = 1;
    localparam int EV_NONE = 0, EV_START = 1, EV_STOP = 2, EV_SNAP = 3, EV_MODE = 4;
    localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_FLUSH = 3, M_SNAP = 4;

    logic iCLK = 1'b0;
    logic iRST, iFVAL, iDVAL_RGB, iDVAL_EDGE;
    logic [1:0] iMODE_SW;
    logic iSTART_N, iSTOP_N, iSNAP_N;
    logic oSEL_EDGE, oHORIZ, oDVAL, oSNAP_DONE, oBUSY;
    logic [CW-1:0] oFRAME_CNT;

    always #5 iCLK = ~iCLK;

    frame_mode_ctrl #(.FLUSH_FRAMES(FF), .CNT_W(CW)) dut (
        .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL_RGB(iDVAL_RGB),
        .iDVAL_EDGE(iDVAL_EDGE), .iMODE_SW(iMODE_SW), .iSTART_N(iSTART_N),
        .iSTOP_N(iSTOP_N), .iSNAP_N(iSNAP_N), .oSEL_EDGE(oSEL_EDGE),
        .oHORIZ(oHORIZ), .oDVAL(oDVAL), .oFRAME_CNT(oFRAME_CNT),
        .oSNAP_DONE(oSNAP_DONE), .oBUSY(oBUSY)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         ev;
        logic [1:0] sw;
        logic       exp_w;
        logic       exp_edge;
        int         exp_cnt;
        logic       exp_busy;
        logic       exp_sel;
        logic       exp_horiz;
        int         exp_done;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic fval, input logic body, input logic exp_w,
                       input logic exp_edge, inout int bad, inout int ndone);
        logic exp;
        @(negedge iCLK);
        iFVAL      = fval;
        iDVAL_RGB  = body ? 1'($urandom_range(0, 1)) : 1'b0;
        iDVAL_EDGE = body ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        exp = exp_w & body & (exp_edge ? iDVAL_EDGE : iDVAL_RGB);
        if (oDVAL !== exp) bad++;
        if (oSNAP_DONE === 1'b1) ndone++;
    endtask

    task automatic blank(input int n);
        int b, d;
        b = 0; d = 0;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, b, d);
    endtask

    // One frame: 2 lead cycles, 36 data cycles, 6 blanking cycles; the event
    // lands well inside the frame.
    task automatic run_frame(input int ev, input logic [1:0] sw, input logic exp_w,
                             input logic exp_edge, output int bad, output int ndone);
        bad = 0; ndone = 0;
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, exp_w, exp_edge, bad, ndone);
        for (int i = 0; i < 36; i++) begin
            if (i == 6) begin
                case (ev)
                    EV_START: iSTART_N = 1'b0;
                    EV_STOP:  iSTOP_N  = 1'b0;
                    EV_SNAP:  iSNAP_N  = 1'b0;
                    EV_MODE:  iMODE_SW = sw;
                    default: ;
                endcase
            end
            if (i == 10) begin
                iSTART_N = 1'b1; iSTOP_N = 1'b1; iSNAP_N = 1'b1;
            end
            cyc(1'b1, 1'b1, exp_w, exp_edge, bad, ndone);
        end
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, exp_w, exp_edge, bad, ndone);
    endtask

    task automatic do_reset();
        iRST = 1'b1; iFVAL = 1'b0; iDVAL_RGB = 1'b0; iDVAL_EDGE = 1'b0;
        iSTART_N = 1'b1; iSTOP_N = 1'b1; iSNAP_N = 1'b1;
        repeat (3) @(negedge iCLK);
        iRST = 1'b0;
        blank(4);
    endtask

    function automatic int dec(input logic [1:0] s);
        if (!s[1]) return 0;
        return s[0] ? 3 : 2;
    endfunction

    function automatic vec_t mk(input int ev, input logic [1:0] sw, input logic w, input logic e,
                                input int c, input logic b, input logic s, input logic h, input int d);
        vec_t v;
        v.ev = ev; v.sw = sw; v.exp_w = w; v.exp_edge = e; v.exp_cnt = c;
        v.exp_busy = b; v.exp_sel = s; v.exp_horiz = h; v.exp_done = d;
        return v;
    endfunction

    // frame-level reference model state
    int m_st, m_snap, m_stop, m_fl, m_cnt, m_pend, m_act;

    initial begin
        int bad, nd, ev, r;
        logic [1:0] sw;
        logic ew, ee;

        //          ev        sw     w  edge cnt busy sel hz done
        tbl[0]  = mk(EV_START, 2'b00, 0, 0, 0, 1, 0, 0, 0);
        tbl[1]  = mk(EV_NONE,  2'b00, 1, 0, 1, 1, 0, 0, 0);
        tbl[2]  = mk(EV_NONE,  2'b00, 1, 0, 2, 1, 0, 0, 0);
        tbl[3]  = mk(EV_NONE,  2'b00, 1, 0, 3, 1, 0, 0, 0);
        tbl[4]  = mk(EV_MODE,  2'b10, 1, 0, 4, 1, 0, 0, 0);
        tbl[5]  = mk(EV_NONE,  2'b10, 0, 1, 4, 1, 1, 0, 0);
        tbl[6]  = mk(EV_NONE,  2'b10, 1, 1, 5, 1, 1, 0, 0);
        tbl[7]  = mk(EV_STOP,  2'b10, 1, 1, 6, 0, 1, 0, 0);
        tbl[8]  = mk(EV_NONE,  2'b10, 0, 1, 6, 0, 1, 0, 0);
        tbl[9]  = mk(EV_SNAP,  2'b10, 0, 1, 6, 1, 1, 0, 0);
        tbl[10] = mk(EV_NONE,  2'b10, 1, 1, 7, 0, 1, 0, 1);
        tbl[11] = mk(EV_NONE,  2'b10, 0, 1, 7, 0, 1, 0, 0);
        tbl[12] = mk(EV_MODE,  2'b11, 0, 1, 7, 0, 1, 0, 0);
        tbl[13] = mk(EV_START, 2'b11, 0, 1, 7, 1, 1, 1, 0);
        tbl[14] = mk(EV_NONE,  2'b11, 1, 1, 8, 1, 1, 1, 0);
        tbl[15] = mk(EV_MODE,  2'b00, 1, 1, 9, 1, 1, 1, 0);
        tbl[16] = mk(EV_STOP,  2'b00, 0, 0, 9, 0, 0, 0, 0);
        tbl[17] = mk(EV_NONE,  2'b00, 0, 0, 9, 0, 0, 0, 0);

        iRST = 1'b1; iFVAL = 1'b0; iDVAL_RGB = 1'b0; iDVAL_EDGE = 1'b0;
        iMODE_SW = 2'b00; iSTART_N = 1'b1; iSTOP_N = 1'b1; iSNAP_N = 1'b1;
        repeat (3) @(negedge iCLK);
        iDVAL_RGB = 1'b1; iDVAL_EDGE = 1'b1;
        #1;
        chk("reset dval", int'(oDVAL), 0);
        chk("reset cnt", int'(oFRAME_CNT), 0);
        chk("reset busy", int'(oBUSY), 0);
        chk("reset sel", int'(oSEL_EDGE), 0);
        chk("reset horiz", int'(oHORIZ), 0);
        chk("reset done", int'(oSNAP_DONE), 0);
        iRST = 1'b0;
        blank(4);

        for (int i = 0; i < 18; i++) begin
            run_frame(tbl[i].ev, tbl[i].sw, tbl[i].exp_w, tbl[i].exp_edge, bad, nd);
            chk($sformatf("row%0d dval", i), bad, 0);
            chk($sformatf("row%0d cnt", i), int'(oFRAME_CNT), tbl[i].exp_cnt % 16);
            chk($sformatf("row%0d busy", i), int'(oBUSY), int'(tbl[i].exp_busy));
            chk($sformatf("row%0d sel", i), int'(oSEL_EDGE), int'(tbl[i].exp_sel));
            chk($sformatf("row%0d horiz", i), int'(oHORIZ), int'(tbl[i].exp_horiz));
            chk($sformatf("row%0d done", i), nd, tbl[i].exp_done);
        end

        // start and stop pressed together: stop wins
        iSTART_N = 1'b0; iSTOP_N = 1'b0;
        blank(4);
        iSTART_N = 1'b1; iSTOP_N = 1'b1;
        blank(6);
        chk("startstop busy", int'(oBUSY), 0);
        run_frame(EV_NONE, 2'b00, 1'b0, 1'b0, bad, nd);
        chk("startstop dval", bad, 0);
        chk("startstop busy2", int'(oBUSY), 0);

        // reset in the middle of a written frame (counter is 9 here)
        iMODE_SW = 2'b11;
        blank(6);
        run_frame(EV_START, 2'b11, 1'b0, 1'b1, bad, nd);
        chk("midrst arm dval", bad, 0);
        bad = 0; nd = 0;
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, bad, nd);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, bad, nd);
        chk("midrst run dval", bad, 0);
        @(negedge iCLK);
        iDVAL_EDGE = 1'b1; iDVAL_RGB = 1'b1;
        #1;
        chk("midrst pre dval", int'(oDVAL), 1);
        iRST = 1'b1;
        @(negedge iCLK);
        #1;
        chk("midrst dval", int'(oDVAL), 0);
        chk("midrst cnt", int'(oFRAME_CNT), 0);
        chk("midrst busy", int'(oBUSY), 0);
        chk("midrst sel", int'(oSEL_EDGE), 0);
        chk("midrst horiz", int'(oHORIZ), 0);
        chk("midrst done", int'(oSNAP_DONE), 0);
        iRST = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, bad, nd);
        blank(6);
        run_frame(EV_NONE, 2'b11, 1'b0, 1'b0, bad, nd);
        chk("midrst after dval", bad, 0);
        chk("midrst after busy", int'(oBUSY), 0);
        chk("midrst after cnt", int'(oFRAME_CNT), 0);

        // counter wrap with a 4-bit counter: 17 frames -> 1
        iMODE_SW = 2'b00;
        do_reset();
        run_frame(EV_START, 2'b00, 1'b0, 1'b0, bad, nd);
        for (int i = 0; i < 17; i++) begin
            run_frame(EV_NONE, 2'b00, 1'b1, 1'b0, bad, nd);
            chk($sformatf("wrap f%0d dval", i), bad, 0);
        end
        chk("wrap cnt", int'(oFRAME_CNT), 1);

        // random frame-level stimulus against the model
        iMODE_SW = 2'b00;
        do_reset();
        m_st = M_IDLE; m_snap = 0; m_stop = 0; m_fl = 0; m_cnt = 0; m_pend = 0; m_act = 0;
        for (int f = 0; f < 50; f++) begin
            r = int'($urandom_range(0, 9));
            ev = (r < 2) ? EV_NONE : (r < 4) ? EV_START : (r == 4) ? EV_STOP :
                 (r < 7) ? EV_SNAP : EV_MODE;
            sw = (ev == EV_MODE) ? 2'($urandom_range(0, 3)) : iMODE_SW;

            // start of frame
            if (m_st == M_ARMED) begin
                if (m_pend != m_act) begin m_st = M_FLUSH; m_fl = 0; end
                else m_st = m_snap ? M_SNAP : M_RUN;
            end else if (m_st == M_RUN) begin
                if (m_pend != m_act) begin m_st = M_FLUSH; m_fl = 0; end
            end else if (m_st == M_FLUSH) begin
                if (m_fl >= FF) m_st = m_snap ? M_SNAP : M_RUN;
            end
            m_act = m_pend;
            ew = (m_st == M_RUN) || (m_st == M_SNAP);
            ee = (m_act >= 2);

            run_frame(ev, sw, ew, ee, bad, nd);

            // mid-frame event
            case (ev)
                EV_START: if (m_st == M_IDLE) begin m_st = M_ARMED; m_snap = 0; end
                EV_SNAP:  if (m_st == M_IDLE) begin m_st = M_ARMED; m_snap = 1; end
                EV_STOP: begin
                    if (m_st == M_ARMED || m_st == M_FLUSH) begin m_st = M_IDLE; m_snap = 0; end
                    else if (m_st == M_RUN) m_stop = 1;
                end
                EV_MODE:  m_pend = dec(sw);
                default: ;
            endcase

            // end of frame
            nd = nd; // done pulses counted by run_frame
            if (m_st == M_RUN) begin
                m_cnt++;
                if (m_stop != 0) begin m_st = M_IDLE; m_stop = 0; end
                chk($sformatf("rnd%0d done", f), nd, 0);
            end else if (m_st == M_SNAP) begin
                m_cnt++;
                m_st = M_IDLE; m_snap = 0;
                chk($sformatf("rnd%0d done", f), nd, 1);
            end else begin
                if (m_st == M_FLUSH) m_fl++;
                chk($sformatf("rnd%0d done", f), nd, 0);
            end

            chk($sformatf("rnd%0d dval", f), bad, 0);
            chk($sformatf("rnd%0d cnt", f), int'(oFRAME_CNT), m_cnt % 16);
            chk($sformatf("rnd%0d busy", f), int'(oBUSY), (m_st != M_IDLE) ? 1 : 0);
            chk($sformatf("rnd%0d sel", f), int'(oSEL_EDGE), (m_act >= 2) ? 1 : 0);
            chk($sformatf("rnd%0d horiz", f), int'(oHORIZ), (m_act == 3) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
